// File: rtl/ecall_print_uart.sv
// Console back-end for the ecall print service. A rising edge on print_flag
// captures print_data. The value is then sent on an 8N1 UART line as 8 uppercase
// ASCII hex digits, MSB nibble first, optionally followed by CR/LF. Halt requests
// are held off until the message in flight has fully left the line.
//
// Ports:
//   clk         system clock, posedge
//   rst         asynchronous reset, active-high
//   print_flag  print request level; one request per 0->1 edge
//   print_data  value to print, sampled in the acceptance cycle
//   halt_in     stop request level
//   uart_txd    serial output, idle high
//   busy        high while a message is being transmitted
//   stall       copy of busy, holds the pipeline
//   halt_out    sticky halt to the top level
//   overflow    sticky: a request arrived while busy and was dropped
module ecall_print_uart #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter bit          NEWLINE      = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        print_flag,
   input  logic [31:0] print_data,
   input  logic        halt_in,
   output logic        uart_txd,
   output logic        busy,
   output logic        stall,
   output logic        halt_out,
   output logic        overflow
);

   localparam int unsigned CntW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]      LastChar = NEWLINE ? 4'd9 : 4'd7;

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [3:0]      char_q, char_d;
   logic [31:0]     shreg_q, shreg_d;
   logic            print_flag_q;  // previous print_flag level for edge detection
   logic            halt_q, halt_d;
   logic            ovf_q, ovf_d;

   logic            req;
   logic            tick;
   logic [3:0]      nib;
   logic [7:0]      chr;

   // Once halted, further requests are ignored entirely (not counted as overflow).
   assign req  = print_flag & ~print_flag_q & ~halt_q;
   assign tick = (cnt_q == '0);

   // Character currently on the line.
   always_comb begin
      nib = shreg_q[{3'd7 - char_q[2:0], 2'b00} +: 4];
      if (char_q == 4'd8) begin
         chr = 8'h0D;
      end else if (char_q == 4'd9) begin
         chr = 8'h0A;
      end else if (nib < 4'd10) begin
         chr = 8'h30 + {4'h0, nib};
      end else begin
         chr = 8'h37 + {4'h0, nib};  // 'A' - 10
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = tick ? CntMax : cnt_q - 1'b1;
      bit_d   = bit_q;
      char_d  = char_q;
      shreg_d = shreg_q;
      halt_d  = halt_q;
      ovf_d   = ovf_q;

      // A request that arrives outside IDLE is dropped, including on the last STOP cycle.
      if (req && (state_q != StIdle)) begin
         ovf_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            cnt_d = CntMax;
            if (req) begin
               shreg_d = print_data;
               char_d  = 4'd0;
               state_d = StStart;
            end else if (halt_in) begin
               halt_d = 1'b1;
            end
         end
         StStart: begin
            if (tick) begin
               bit_d   = 3'd0;
               state_d = StData;
            end
         end
         StData: begin
            if (tick) begin
               if (bit_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         StStop: begin
            if (tick) begin
               if (char_q == LastChar) begin
                  state_d = StIdle;
               end else begin
                  char_d  = char_q + 4'd1;
                  state_d = StStart;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         bit_q        <= '0;
         char_q       <= '0;
         shreg_q      <= '0;
         print_flag_q <= 1'b0;
         halt_q       <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         char_q       <= char_d;
         shreg_q      <= shreg_d;
         print_flag_q <= print_flag;
         halt_q       <= halt_d;
         ovf_q        <= ovf_d;
      end
   end

   // Line level decoded straight from state so reset forces it high immediately.
   always_comb begin
      uart_txd = 1'b1;
      unique case (state_q)
         StIdle:  uart_txd = 1'b1;
         StStart: uart_txd = 1'b0;
         StData:  uart_txd = chr[bit_q];
         StStop:  uart_txd = 1'b1;
      endcase
   end

   assign busy     = (state_q != StIdle);
   assign stall    = busy;
   assign halt_out = halt_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_ecall_print_uart.sv
// Bench for ecall_print_uart: two instances (with and without CR/LF), a waveform
// model checked every cycle, a line decoder, and literal expectations per scenario.
module tb_ecall_print_uart;

   localparam int CPB = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  pf  = '0;
   logic [1:0]  hin = '0;
   logic [31:0] pd [2];
   logic [1:0]  txd, busy, stall, hout, ovf;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ecall_print_uart #(.CLKS_PER_BIT(CPB), .NEWLINE(1'b1)) u_dut0 (
      .clk(clk), .rst(rst), .print_flag(pf[0]), .print_data(pd[0]), .halt_in(hin[0]),
      .uart_txd(txd[0]), .busy(busy[0]), .stall(stall[0]), .halt_out(hout[0]),
      .overflow(ovf[0])
   );

   ecall_print_uart #(.CLKS_PER_BIT(CPB), .NEWLINE(1'b0)) u_dut1 (
      .clk(clk), .rst(rst), .print_flag(pf[1]), .print_data(pd[1]), .halt_in(hin[1]),
      .uart_txd(txd[1]), .busy(busy[1]), .stall(stall[1]), .halt_out(hout[1]),
      .overflow(ovf[1])
   );

   task automatic check(input string nm, input int inst, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %0h, expected %0h", nm, inst, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int nch(input int i);
      return (i == 0) ? 10 : 8;
   endfunction

   function automatic logic [7:0] exp_char(input logic [31:0] v, input int idx);
      int n;
      if (idx == 8) return 8'h0D;
      if (idx == 9) return 8'h0A;
      n = int'((v >> (28 - 4 * idx)) & 32'hF);
      return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
   endfunction

   logic m_wave [2][400];
   int   m_left [2] = '{0, 0};
   int   m_pos  [2] = '{0, 0};
   logic m_prev [2] = '{1'b0, 1'b0};
   logic m_halt [2] = '{1'b0, 1'b0};
   logic m_ovf  [2] = '{1'b0, 1'b0};

   // Expected line level for every cycle of a whole message.
   task automatic build(input int i, input logic [31:0] v);
      int k;
      logic [7:0] ch;
      logic lvl;
      k = 0;
      for (int c = 0; c < nch(i); c++) begin
         ch = exp_char(v, c);
         for (int b = 0; b < 10; b++) begin
            lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : ch[b-1];
            for (int r = 0; r < CPB; r++) begin
               m_wave[i][k] = lvl;
               k++;
            end
         end
      end
   endtask

   always @(posedge clk or posedge rst) begin
      logic req;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_prev[i] = 1'b0; m_left[i] = 0; m_pos[i] = 0; m_halt[i] = 1'b0; m_ovf[i] = 1'b0;
         end else begin
            req = pf[i] && !m_prev[i] && !m_halt[i];
            m_prev[i] = pf[i];
            if (m_left[i] > 0) begin
               m_left[i]--;
               m_pos[i]++;
               if (req) m_ovf[i] = 1'b1;
            end else if (req) begin
               build(i, pd[i]);
               m_left[i] = nch(i) * 10 * CPB;
               m_pos[i]  = 0;
            end else if (hin[i]) begin
               m_halt[i] = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic exp_b, exp_t;
      for (int i = 0; i < 2; i++) begin
         exp_b = (m_left[i] > 0);
         exp_t = exp_b ? m_wave[i][m_pos[i]] : 1'b1;
         check("txd",      i, 32'(txd[i]),   32'(exp_t));
         check("busy",     i, 32'(busy[i]),  32'(exp_b));
         check("stall",    i, 32'(stall[i]), 32'(exp_b));
         check("halt_out", i, 32'(hout[i]),  32'(m_halt[i]));
         check("overflow", i, 32'(ovf[i]),   32'(m_ovf[i]));
      end
   end

   // ---------------- line decoder ----------------
   logic       rx_act [2] = '{1'b0, 1'b0};
   int         rx_cnt [2] = '{0, 0};
   logic [7:0] rx_sh  [2];
   logic [7:0] rxbuf  [2][64];
   int         rxn    [2] = '{0, 0};

   always @(negedge clk) begin
      int k;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            rx_act[i] = 1'b0;
            rxn[i]    = 0;
         end else if (!rx_act[i]) begin
            if (!txd[i]) begin
               rx_act[i] = 1'b1;
               rx_cnt[i] = 0;
            end
         end else begin
            rx_cnt[i]++;
            if (rx_cnt[i] % CPB == CPB / 2) begin
               k = rx_cnt[i] / CPB;
               if (k >= 1 && k <= 8) begin
                  rx_sh[i][k-1] = txd[i];
               end else if (k == 9) begin
                  if (rxn[i] < 64) rxbuf[i][rxn[i]] = rx_sh[i];
                  rxn[i]++;
                  rx_act[i] = 1'b0;
               end
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic pulse(input int i, input logic [31:0] v);
      @(negedge clk);
      pd[i] = v;
      pf[i] = 1'b1;
      @(negedge clk);
      pf[i] = 1'b0;
      pd[i] = ~v;
   endtask

   task automatic wait_idle(input int i, output int n);
      n = busy[i] ? 1 : 0;
      while (busy[i] && n < 5000) begin
         @(negedge clk);
         if (busy[i]) n++;
      end
   endtask

   task automatic check_bytes(input int i, input int base, input string s);
      check("rx_count", i, rxn[i] - base, s.len());
      for (int k = 0; k < s.len(); k++) begin
         if (base + k < 64) check("rx_byte", i, 32'(rxbuf[i][base+k]), 32'(s[k]));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, b;
      pd[0] = '0;
      pd[1] = '0;
      repeat (3) @(negedge clk);
      #1;
      check("init_txd", 0, 32'(txd[0]), 1);
      check("init_busy", 0, 32'(busy[0]), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // 1-cycle pulse, 000000A5 + CR/LF
      b = rxn[0];
      pulse(0, 32'h0000_00A5);
      check("start_bit", 0, 32'(txd[0]), 0);
      check("busy_on", 0, 32'(busy[0]), 1);
      wait_idle(0, n);
      check("busy_len_a5", 0, n, 400);
      repeat (5) @(negedge clk);
      check_bytes(0, b, "000000A5\r\n");

      // Level held for 1000 cycles: one message only
      b = rxn[0];
      @(negedge clk);
      pd[0] = 32'hDEAD_BEEF;
      pf[0] = 1'b1;
      @(negedge clk);
      pd[0] = '0;
      repeat (999) @(negedge clk);
      pf[0] = 1'b0;
      repeat (5) @(negedge clk);
      check("held_busy", 0, 32'(busy[0]), 0);
      check("held_ovf", 0, 32'(ovf[0]), 0);
      check_bytes(0, b, "DEADBEEF\r\n");

      // Second pulse 50 cycles into a message
      b = rxn[0];
      pulse(0, 32'h89AB_CDEF);
      repeat (48) @(negedge clk);
      pulse(0, 32'h1111_1111);
      check("ovf_set", 0, 32'(ovf[0]), 1);
      wait_idle(0, n);
      repeat (5) @(negedge clk);
      check_bytes(0, b, "89ABCDEF\r\n");
      check("ovf_sticky", 0, 32'(ovf[0]), 1);

      // Reset in the middle of a data bit
      pulse(0, 32'h1234_5678);
      repeat (15) @(negedge clk);
      check("pre_rst_busy", 0, 32'(busy[0]), 1);
      check("pre_rst_txd", 0, 32'(txd[0]), 0);
      #1 rst = 1'b1;
      #1;
      check("rst_txd", 0, 32'(txd[0]), 1);
      check("rst_busy", 0, 32'(busy[0]), 0);
      check("rst_stall", 0, 32'(stall[0]), 0);
      check("rst_halt", 0, 32'(hout[0]), 0);
      check("rst_ovf", 0, 32'(ovf[0]), 0);
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);

      // No CR/LF instance
      b = rxn[1];
      pulse(1, 32'h1234_5678);
      check("start_bit", 1, 32'(txd[1]), 0);
      wait_idle(1, n);
      check("busy_len_8", 1, n, 320);
      repeat (5) @(negedge clk);
      check_bytes(1, b, "12345678");

      // Halt raised mid-message
      b = rxn[0];
      pulse(0, 32'h0000_0001);
      repeat (99) @(negedge clk);
      hin[0] = 1'b1;
      n = 0;
      while (busy[0] && n < 5000) begin
         check("halt_wait", 0, 32'(hout[0]), 0);
         @(negedge clk);
         n++;
      end
      check("halt_at_fall", 0, 32'(hout[0]), 0);
      @(negedge clk);
      check("halt_set", 0, 32'(hout[0]), 1);
      pulse(0, 32'hFFFF_FFFF);
      check("halted_busy", 0, 32'(busy[0]), 0);
      repeat (50) @(negedge clk);
      check("halted_busy2", 0, 32'(busy[0]), 0);
      check("halted_ovf", 0, 32'(ovf[0]), 0);
      check_bytes(0, b, "00000001\r\n");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
